fastserial_device: RTL and testbench

//  Device (FT2232H-side) end of the opto-isolated fast serial link. It receives frames
//  on FSDI and drives FSDO and FSCTS, timed by the host-supplied FSCLK. Used as a loopback
//  or bridge endpoint on a second board, and as a synthesizable partner in benches.
//  The byte side uses valid/ready streams and connects to Avalon-ST byte adapters.

---
 rtl/fastserial_pkg.sv | 32 +++
 rtl/fs_edge_sync.sv | 37 +++
 rtl/fastserial_device.sv | 217 +++++++++++++++++++++
 tb/tb_fastserial_device.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fastserial_pkg.sv
// Shared constants, FSM encodings and the debug view for the fast serial device.
package fastserial_pkg;

  localparam int FS_DATA_BITS  = 8;
  localparam int FS_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1,
    R_SRC  = 2'd2
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_START = 3'd1,
    T_DATA  = 3'd2,
    T_SRC   = 3'd3,
    T_STOP  = 3'd4
  } tx_state_e;

  typedef struct packed {
    rx_state_e  rx_state;
    tx_state_e  tx_state;
    logic [2:0] rx_bit;
    logic [2:0] tx_bit;
    logic       fsclk_sync;
    logic       fsdi_sync;
    logic       fsdi_rise;
    logic       fsdi_fall;
  } fs_debug_t;

endpackage

// File: rtl/fs_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, with 1-cycle rise/fall strobes
// derived from the synchronized level.
module fs_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/fastserial_device.sv
// Device end of the fast serial link: RX frame decoder with CTS flow control and an
// independent TX frame generator, both paced by edges of the host FSCLK.
module fastserial_device
  import fastserial_pkg::*;
#(
  parameter logic SRC_BIT     = 1'b0,
  parameter int   CTS_HOLD    = 4,
  parameter int   SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_fsclk,
  input  logic       i_fsdi,
  output logic       o_fsdo,
  output logic       o_fscts,
  output logic [7:0] o_rx_data,
  output logic       o_rx_src,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_overrun,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output fs_debug_t  o_dbg
);

  // Valid/ready: a byte moves on any cycle where valid & ready are both high at the
  // clock edge; the source holds data and valid stable until that edge.
  logic fsclk_level, fsclk_rise, fsclk_fall;
  logic fsdi_level, fsdi_rise, fsdi_fall;

  fs_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_fsclk_sync (
    .clk(i_clk), .reset(i_reset), .d(i_fsclk),
    .level(fsclk_level), .rise(fsclk_rise), .fall(fsclk_fall)
  );

  fs_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_fsdi_sync (
    .clk(i_clk), .reset(i_reset), .d(i_fsdi),
    .level(fsdi_level), .rise(fsdi_rise), .fall(fsdi_fall)
  );

  rx_state_e  rx_state_q, rx_state_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_accept_q, rx_accept_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_src_q, rx_src_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       fscts_q, fscts_d;
  logic [7:0] cts_cnt_q, cts_cnt_d;
  logic       rx_hs;

  tx_state_e  tx_state_q, tx_state_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       fsdo_q, fsdo_d;

  assign rx_hs = rx_valid_q & i_rx_ready;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_accept_d  = rx_accept_q;
    rx_data_d    = rx_data_q;
    rx_src_d     = rx_src_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;
    fscts_d      = fscts_q;
    cts_cnt_d    = cts_cnt_q;

    // CTS stays low while the byte is held, then for CTS_HOLD cycles after it is taken.
    if (rx_hs) begin
      rx_valid_d = 1'b0;
      cts_cnt_d  = 8'(CTS_HOLD);
    end else if (cts_cnt_q != 8'd0) begin
      cts_cnt_d = cts_cnt_q - 8'd1;
      if (cts_cnt_q == 8'd1) fscts_d = 1'b1;
    end

    case (rx_state_q)
      R_IDLE: begin
        if (fsclk_rise && !fsdi_level) begin
          rx_state_d  = R_DATA;
          rx_bit_d    = 3'd0;
          rx_accept_d = fscts_q;
          if (fscts_q) fscts_d = 1'b0;
        end
      end
      R_DATA: begin
        if (fsclk_rise) begin
          rx_shift_d = {fsdi_level, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = R_SRC;
        end
      end
      R_SRC: begin
        if (fsclk_rise) begin
          rx_state_d = R_IDLE;
          if (rx_accept_q) begin
            rx_data_d  = rx_shift_q;
            rx_src_d   = fsdi_level;
            rx_valid_d = 1'b1;
          end else begin
            rx_overrun_d = 1'b1;
          end
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fsdo_d     = fsdo_q;

    case (tx_state_q)
      T_IDLE: begin
        if (i_tx_valid) begin
          tx_shift_d = i_tx_data;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (fsclk_fall) begin
          fsdo_d     = 1'b0;
          tx_bit_d   = 3'd0;
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (fsclk_fall) begin
          fsdo_d     = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = T_SRC;
        end
      end
      T_SRC: begin
        if (fsclk_fall) begin
          fsdo_d     = SRC_BIT;
          tx_bit_d   = 3'd0;
          tx_state_d = T_STOP;
        end
      end
      T_STOP: begin
        // First fall opens the stop slot; the next fall closes it and frees the link.
        if (fsclk_fall) begin
          if (tx_bit_q == 3'd0) begin
            fsdo_d   = 1'b1;
            tx_bit_d = 3'd1;
          end else begin
            tx_state_d = T_IDLE;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state_q   <= R_IDLE;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rx_accept_q  <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_src_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      fscts_q      <= 1'b1;
      cts_cnt_q    <= 8'd0;
      tx_state_q   <= T_IDLE;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'd0;
      fsdo_q       <= 1'b1;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_accept_q  <= rx_accept_d;
      rx_data_q    <= rx_data_d;
      rx_src_q     <= rx_src_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      fscts_q      <= fscts_d;
      cts_cnt_q    <= cts_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      fsdo_q       <= fsdo_d;
    end
  end

  assign o_fsdo       = fsdo_q;
  assign o_fscts      = fscts_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_src     = rx_src_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_rx_overrun = rx_overrun_q;
  assign o_tx_ready   = (tx_state_q == T_IDLE);

  always_comb begin
    o_dbg.rx_state   = rx_state_q;
    o_dbg.tx_state   = tx_state_q;
    o_dbg.rx_bit     = rx_bit_q;
    o_dbg.tx_bit     = tx_bit_q;
    o_dbg.fsclk_sync = fsclk_level;
    o_dbg.fsdi_sync  = fsdi_level;
    o_dbg.fsdi_rise  = fsdi_rise;
    o_dbg.fsdi_fall  = fsdi_fall;
  end

endmodule

// File: tb/tb_fastserial_device.sv
// Bench for fastserial_device: host-side FSCLK/FSDI driver, RX scoreboard and TX bit capture.
module tb_fastserial_device;
  import fastserial_pkg::*;

  localparam int   HALF     = 8;   // i_clk cycles per FSCLK half period
  localparam int   CTS_HOLD = 4;
  localparam logic SRC_BIT  = 1'b0;

  logic       clk = 1'b0;
  logic       i_reset, i_fsclk, i_fsdi, i_rx_ready, i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_fsdo, o_fscts, o_rx_src, o_rx_valid, o_rx_overrun, o_tx_ready;
  logic [7:0] o_rx_data;
  fs_debug_t  o_dbg;

  fastserial_device #(.SRC_BIT(SRC_BIT), .CTS_HOLD(CTS_HOLD), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_fsclk(i_fsclk), .i_fsdi(i_fsdi),
    .o_fsdo(o_fsdo), .o_fscts(o_fscts), .o_rx_data(o_rx_data), .o_rx_src(o_rx_src),
    .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_overrun(o_rx_overrun),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .o_dbg(o_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, rx_count = 0, ovr_cnt = 0, hs_edge = 0, cts_edge = 0;
  logic cts_prev = 1'b1;
  logic [8:0] exp_q[$];  // {src, data}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard: RX handshakes, overrun pulses and CTS release timing
  always begin : monitor
    logic [8:0] e;
    @(negedge clk);
    #1;
    if (o_rx_valid && i_rx_ready) begin
      hs_edge = cyc + 1;
      rx_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got 0x%0h with nothing expected", {o_rx_src, o_rx_data});
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", {23'd0, o_rx_src, o_rx_data}, {23'd0, e});
      end
    end
    if (o_rx_overrun) ovr_cnt++;
    if (o_fscts && !cts_prev) cts_edge = cyc;
    cts_prev = o_fscts;
  end

  // driver tasks
  task automatic host_frame(input logic en, input logic [7:0] b, input logic src,
                            input logic dev_active, input int n_slots,
                            output logic [11:0] cap);
    cap = '1;
    for (int s = 0; s < n_slots; s++) begin
      logic bit_v;
      bit_v = 1'b1;
      if (en) begin
        if (s == 0) bit_v = 1'b0;
        else if (s <= 8) bit_v = b[s-1];
        else if (s == 9) bit_v = src;
      end
      i_fsclk = 1'b0;
      i_fsdi  = bit_v;
      repeat (HALF) @(negedge clk);
      cap[s] = o_fsdo;
      if (en && s == 1) check("cts_low_in_frame", {31'd0, o_fscts}, 32'd0);
      if (dev_active && s == 10) check("tx_ready_stop_slot", {31'd0, o_tx_ready}, 32'd0);
      i_fsclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    int n;
    n = 0;
    i_tx_data  = b;
    i_tx_valid = 1'b1;
    while (!o_tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    i_tx_valid = 1'b0;
    check("tx_accepted", {31'd0, o_tx_ready}, 32'd0);
  endtask

  typedef struct {
    logic        host_en;
    logic [7:0]  host_byte;
    logic        host_src;
    logic        dev_en;
    logic [7:0]  dev_byte;
    logic [10:0] exp_fsdo;  // slot s of the device frame at bit s
  } vec_t;

  vec_t vecs[5];
  logic [11:0] cap;
  int rx_before, n;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 11'h478};
    vecs[1] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'hF0, 11'h5E0};
    vecs[2] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 11'h5FE};
    vecs[3] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 11'h402};
    vecs[4] = '{1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 11'h7FF};

    i_reset = 1'b1; i_fsclk = 1'b1; i_fsdi = 1'b1;
    i_rx_ready = 1'b1; i_tx_valid = 1'b0; i_tx_data = 8'h00;
    repeat (5) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_fsdo", {31'd0, o_fsdo}, 32'd1);
    check("rst_fscts", {31'd0, o_fscts}, 32'd1);
    check("rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, o_rx_data}, 32'd0);
    check("rst_rx_src", {31'd0, o_rx_src}, 32'd0);
    check("rst_overrun", {31'd0, o_rx_overrun}, 32'd0);

    // single RX byte with CTS release timing
    exp_q.push_back({1'b1, 8'hA5});
    host_frame(1'b1, 8'hA5, 1'b1, 1'b0, 12, cap);
    check("a5_rx_count", rx_count, 1);
    check("a5_cts_hold", cts_edge - hs_edge, CTS_HOLD);
    check("a5_fsdo_idle", {20'd0, cap}, 32'hFFF);

    // table: TX alone, full duplex, RX alone
    for (int i = 0; i < 5; i++) begin
      rx_before = rx_count;
      if (vecs[i].host_en) exp_q.push_back({vecs[i].host_src, vecs[i].host_byte});
      if (vecs[i].dev_en) tx_send(vecs[i].dev_byte);
      host_frame(vecs[i].host_en, vecs[i].host_byte, vecs[i].host_src, vecs[i].dev_en, 12, cap);
      check($sformatf("vec%0d_fsdo", i), {21'd0, cap[10:0]}, {21'd0, vecs[i].exp_fsdo});
      check($sformatf("vec%0d_rx_count", i), rx_count - rx_before, vecs[i].host_en ? 1 : 0);
      check($sformatf("vec%0d_tx_ready", i), {31'd0, o_tx_ready}, 32'd1);
      check($sformatf("vec%0d_cts", i), {31'd0, o_fscts}, 32'd1);
    end
    check("duplex_no_overrun", ovr_cnt, 0);

    // overrun: consumer stalls, second frame dropped, third frame clean
    i_rx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h11});
    host_frame(1'b1, 8'h11, 1'b0, 1'b0, 12, cap);
    check("ovr_first_valid", {31'd0, o_rx_valid}, 32'd1);
    check("ovr_first_data", {24'd0, o_rx_data}, 32'h11);
    host_frame(1'b1, 8'h22, 1'b1, 1'b0, 12, cap);
    check("ovr_pulse_count", ovr_cnt, 1);
    check("ovr_data_held", {24'd0, o_rx_data}, 32'h11);
    check("ovr_valid_held", {31'd0, o_rx_valid}, 32'd1);
    i_rx_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ovr_hs_done", exp_q.size(), 0);
    repeat (CTS_HOLD + 2) @(negedge clk);
    check("ovr_cts_back", {31'd0, o_fscts}, 32'd1);
    rx_before = rx_count;
    exp_q.push_back({1'b1, 8'h33});
    host_frame(1'b1, 8'h33, 1'b1, 1'b0, 12, cap);
    check("ovr_third_count", rx_count - rx_before, 1);
    check("ovr_no_new_pulse", ovr_cnt, 1);

    // reset in the middle of a transmitted frame
    tx_send(8'h00);
    host_frame(1'b0, 8'h00, 1'b0, 1'b0, 5, cap);
    check("mid_tx_bits", {27'd0, cap[4:0]}, 32'd0);
    i_reset = 1'b1;
    @(negedge clk);
    check("mid_rst_fsdo", {31'd0, o_fsdo}, 32'd1);
    check("mid_rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("post_rst_fsdo", {31'd0, o_fsdo}, 32'd1);
    tx_send(8'h81);
    host_frame(1'b0, 8'h00, 1'b0, 1'b1, 12, cap);
    check("post_rst_81", {21'd0, cap[10:0]}, 32'h502);

    check("exp_q_empty", exp_q.size(), 0);
    check("overrun_total", ovr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
